// File: rtl/sfr_bank.sv
// SFR bank: synchronised host strobes, RW/RO/ID register map, per-register strobes, key-unlock write protection.
// Latency: register effects land 3 clk after a host strobe rises; host is never stalled.
module sfr_bank #(
  parameter int                 AW         = 6,
  parameter int                 DW         = 8,
  parameter int                 NREG       = 58,
  parameter logic [NREG-1:0]    RW_MAP     = '0,
  parameter logic [NREG*DW-1:0] RST_VAL    = '0,
  parameter logic [DW-1:0]      ID0        = 8'hd0,
  parameter logic [DW-1:0]      ID1        = 8'h52,
  parameter logic [AW-1:0]      KEY_ADDR   = 6'h03,
  parameter logic [DW-1:0]      KEY1       = 8'h55,
  parameter logic [DW-1:0]      KEY2       = 8'haa,
  parameter logic [AW-1:0]      WP_BASE    = 6'h20,
  parameter int                 UNLOCK_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        sfr_addrs,
  input  logic [DW-1:0]        sfr_wdata,
  input  logic                 sfr_wctrl,
  input  logic                 sfr_rctrl,
  output logic [DW-1:0]        sfr_rdata,
  output logic [NREG*DW-1:0]   reg_q,
  output logic [NREG-1:0]      reg_wstb,
  output logic [NREG-1:0]      rd_stb,
  input  logic [NREG*DW-1:0]   sts_i,
  output logic                 unlocked,
  output logic                 wp_err
);

  localparam int ASPACE = 1 << AW;
  localparam int TW     = $clog2(UNLOCK_CYC + 1);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_KEY1     = 2'd1,
    S_UNLOCKED = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;

  logic [2:0]      wsync, rsync;
  logic            wp, rp;

  logic [ASPACE-1:0] rw_vec;
  logic [DW-1:0]     rd_tab [ASPACE];
  logic [NREG-1:0]   addr_hit;
  logic [NREG-1:0]   wr_en;
  logic [DW-1:0]     key_sts;

  logic            rw_hit, prot_hit, key_wr, key_rd, wr_acc, wr_blk;

  // Strobe synchronisers: two metastability flops plus an edge-detect flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wsync <= '0;
      rsync <= '0;
    end else begin
      wsync <= {wsync[1:0], sfr_wctrl};
      rsync <= {rsync[1:0], sfr_rctrl};
    end
  end

  assign wp = wsync[1] & ~wsync[2];
  assign rp = rsync[1] & ~rsync[2];

  assign rw_hit   = rw_vec[sfr_addrs];
  assign prot_hit = (sfr_addrs >= WP_BASE);
  assign key_wr   = wp & (sfr_addrs == KEY_ADDR);
  assign key_rd   = rp & (sfr_addrs == KEY_ADDR);
  assign wr_acc   = wp & rw_hit & ~(prot_hit & ~unlocked);
  assign wr_blk   = wp & rw_hit & prot_hit & ~unlocked;
  assign wr_en    = addr_hit & {NREG{wr_acc}};

  assign unlocked = (state == S_UNLOCKED);
  assign key_sts  = DW'({state, wp_err, unlocked});

  // Per-address map: ID/key slots are fixed, RW slots hold storage, the rest mirror sts_i.
  for (genvar a = 0; a < ASPACE; a++) begin : g_addr
    if (a >= NREG) begin : g_none
      assign rw_vec[a] = 1'b0;
      assign rd_tab[a] = '0;
    end else begin : g_impl
      assign addr_hit[a] = (sfr_addrs == AW'(a));
      if (a == 0 || a == 1 || a == int'(KEY_ADDR)) begin : g_fixed
        logic unused_sts;
        assign unused_sts            = ^sts_i[a*DW +: DW];
        assign rw_vec[a]             = 1'b0;
        assign reg_q[a*DW +: DW]     = '0;
        assign rd_tab[a]             = (a == 0) ? ID0 : ((a == 1) ? ID1 : key_sts);
      end else if (RW_MAP[a]) begin : g_rw
        logic [DW-1:0] q;
        logic          unused_sts;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            q <= RST_VAL[a*DW +: DW];
          end else if (wr_en[a]) begin
            q <= sfr_wdata;
          end
        end
        assign unused_sts        = ^sts_i[a*DW +: DW];
        assign rw_vec[a]         = 1'b1;
        assign reg_q[a*DW +: DW] = q;
        assign rd_tab[a]         = q;
      end else begin : g_ro
        assign rw_vec[a]         = 1'b0;
        assign reg_q[a*DW +: DW] = '0;
        assign rd_tab[a]         = sts_i[a*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_LOCKED;
      timer <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
    end
  end

  // A write to any non-key address in KEY1 drops the sequence; key writes always leave UNLOCKED.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    case (state)
      S_LOCKED: begin
        if (key_wr && sfr_wdata == KEY1) begin
          state_nx = S_KEY1;
        end
      end
      S_KEY1: begin
        if (key_wr && sfr_wdata == KEY2) begin
          state_nx = S_UNLOCKED;
          timer_nx = TW'(UNLOCK_CYC - 1);
        end else if (wp) begin
          state_nx = S_LOCKED;
        end
      end
      S_UNLOCKED: begin
        if (key_wr || timer == '0) begin
          state_nx = S_LOCKED;
          timer_nx = '0;
        end else begin
          timer_nx = timer - TW'(1);
        end
      end
      default: begin
        state_nx = S_LOCKED;
        timer_nx = '0;
      end
    endcase
  end

  // Read mux samples pre-write contents, so a same-cycle write/read returns the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sfr_rdata <= '0;
      reg_wstb  <= '0;
      rd_stb    <= '0;
      wp_err    <= 1'b0;
    end else begin
      reg_wstb <= wr_en;
      rd_stb   <= addr_hit & {NREG{rp}};
      if (rp) begin
        sfr_rdata <= rd_tab[sfr_addrs];
      end
      if (wr_blk) begin
        wp_err <= 1'b1;
      end else if (key_rd) begin
        wp_err <= 1'b0;
      end
    end
  end

endmodule
